// File: rtl/lock_display_sequencer_pkg.sv
// Shared display codes, state encoding and fixed messages for the lock display path.
// The downstream seven-segment encoders decode exactly these 4-bit codes.
package lock_display_pkg;

    localparam logic [3:0] DISP_0    = 4'h0;
    localparam logic [3:0] DISP_1    = 4'h1;
    localparam logic [3:0] DISP_2    = 4'h2;
    localparam logic [3:0] DISP_3    = 4'h3;
    localparam logic [3:0] DISP_4    = 4'h4;
    localparam logic [3:0] DISP_E    = 4'h5;
    localparam logic [3:0] DISP_r    = 4'h6;
    localparam logic [3:0] DISP_o    = 4'h7;
    localparam logic [3:0] DISP_L    = 4'h8;
    localparam logic [3:0] DISP_c    = 4'h9;
    localparam logic [3:0] DISP_U    = 4'hA;
    localparam logic [3:0] DISP_n    = 4'hB;
    localparam logic [3:0] DISP_DASH = 4'hF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ENTRY = 2'd1,
        ERROR = 2'd2
    } state_t;

    // Messages are written leftmost digit first, so index 0 lands in bits [3:0].
    localparam logic [23:0] MSG_LOCKED   = {DISP_DASH, DISP_DASH, DISP_DASH, DISP_L, DISP_o, DISP_c};
    localparam logic [23:0] MSG_UNLOCKED = {DISP_DASH, DISP_U, DISP_n, DISP_L, DISP_o, DISP_c};
    localparam logic [23:0] MSG_ERROR    = {DISP_E, DISP_r, DISP_r, DISP_o, DISP_r, DISP_DASH};
    localparam logic [23:0] MSG_BLANK    = {6{DISP_DASH}};

endpackage

// File: rtl/lock_display_sequencer_if.sv
// Bundle between the lock controller (master) and the display sequencer (slave).
interface lock_display_sequencer_if #(
    parameter int NUM_DISPLAYS = 6
);
    logic                      locked;
    logic                      digit_valid;
    logic [2:0]                digit_value;
    logic                      clear;
    logic                      error;
    logic [4*NUM_DISPLAYS-1:0] hex_codes;
    logic [2:0]                entry_count;
    logic                      entry_full;
    logic                      busy;

    modport master (
        output locked, digit_valid, digit_value, clear, error,
        input  hex_codes, entry_count, entry_full, busy
    );

    modport slave (
        input  locked, digit_valid, digit_value, clear, error,
        output hex_codes, entry_count, entry_full, busy
    );
endinterface

// File: rtl/lock_display_sequencer_blink_timer.sv
// Error-message duration and blink-phase timer. Outputs look one cycle ahead so the
// sequencer can register its display from them without adding latency.
module lock_blink_timer #(
    parameter int BLINK_CYCLES = 25000000,
    parameter int ERROR_CYCLES = 150000000
) (
    input  logic clock,
    input  logic reset,
    input  logic start,
    output logic active,
    output logic phase
);

    localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam int DW = (ERROR_CYCLES > 1) ? $clog2(ERROR_CYCLES) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);
    localparam logic [DW-1:0] DUR_LAST   = DW'(ERROR_CYCLES - 1);
    // State after the first error cycle has already elapsed (counts start at 1).
    localparam logic          START_WRAP  = (BLINK_CYCLES == 1);
    localparam logic          START_ALIVE = (ERROR_CYCLES > 1);

    logic [BW-1:0] blink_cnt;
    logic [DW-1:0] dur_cnt;

    // active/phase describe the cycle after the current one: phase = "on" next cycle,
    // active = the error message is still showing next cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            blink_cnt <= '0;
            dur_cnt   <= '0;
            active    <= 1'b0;
            phase     <= 1'b0;
        end else if (start) begin
            blink_cnt <= START_WRAP ? '0 : BW'(1);
            dur_cnt   <= START_ALIVE ? DW'(1) : '0;
            phase     <= START_ALIVE ? ~START_WRAP : 1'b0;
            active    <= START_ALIVE;
        end else if (active) begin
            if (dur_cnt == DUR_LAST) begin
                blink_cnt <= '0;
                dur_cnt   <= '0;
                phase     <= 1'b0;
                active    <= 1'b0;
            end else begin
                dur_cnt <= dur_cnt + DW'(1);
                if (blink_cnt == BLINK_LAST) begin
                    blink_cnt <= '0;
                    phase     <= ~phase;
                end else begin
                    blink_cnt <= blink_cnt + BW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/lock_display_sequencer.sv
// Turns lock status, keypad entry and error events into per-digit seven-segment codes.
// All outputs are registered; the blink/duration timing lives in lock_blink_timer.
module lock_display_sequencer
    import lock_display_pkg::*;
#(
    parameter int NUM_DISPLAYS = 6,
    parameter int CODE_LEN     = 4,
    parameter int BLINK_CYCLES = 25000000,
    parameter int ERROR_CYCLES = 150000000
) (
    input  logic                    clock,
    input  logic                    reset,
    lock_display_sequencer_if.slave bus
);

    localparam int HEX_W = 4 * NUM_DISPLAYS;

    generate
        if (NUM_DISPLAYS != 6) begin : g_bad_displays
            $error("lock_display_sequencer: NUM_DISPLAYS must be 6");
        end
        if (CODE_LEN < 1 || CODE_LEN > 4) begin : g_bad_code_len
            $error("lock_display_sequencer: CODE_LEN must be 1..4");
        end
        if (BLINK_CYCLES < 1 || ERROR_CYCLES < 1) begin : g_bad_cycles
            $error("lock_display_sequencer: cycle counts must be positive");
        end
    endgenerate

    state_t                       state;
    logic [CODE_LEN-1:0][3:0]     entry_buf;
    logic [CODE_LEN-1:0][3:0]     shift_buf;
    logic [HEX_W-1:0]             shift_hex;
    logic [HEX_W-1:0]             idle_hex;
    logic                         digit_ok;
    logic                         tmr_active;
    logic                         tmr_phase;

    lock_blink_timer #(
        .BLINK_CYCLES (BLINK_CYCLES),
        .ERROR_CYCLES (ERROR_CYCLES)
    ) u_timer (
        .clock  (clock),
        .reset  (reset),
        .start  (bus.error),
        .active (tmr_active),
        .phase  (tmr_phase)
    );

    // Newest digit enters at index 0; positions never written keep the dash code.
    always_comb begin
        shift_buf[0] = {1'b0, bus.digit_value};
        for (int i = 1; i < CODE_LEN; i++) begin
            shift_buf[i] = entry_buf[i-1];
        end
        shift_hex = {NUM_DISPLAYS{DISP_DASH}};
        for (int i = 0; i < CODE_LEN; i++) begin
            shift_hex[i*4 +: 4] = shift_buf[i];
        end
    end

    assign idle_hex = bus.locked ? MSG_LOCKED : MSG_UNLOCKED;
    assign digit_ok = bus.digit_valid && (bus.digit_value <= 3'd4) && !bus.entry_full;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            entry_buf       <= {CODE_LEN{DISP_DASH}};
            bus.entry_count <= 3'd0;
            bus.entry_full  <= 1'b0;
            bus.busy        <= 1'b0;
            bus.hex_codes   <= MSG_LOCKED;
        end else if (bus.error) begin
            // Any state, including ERROR itself: the timer restarts alongside.
            state           <= ERROR;
            entry_buf       <= {CODE_LEN{DISP_DASH}};
            bus.entry_count <= 3'd0;
            bus.entry_full  <= 1'b0;
            bus.busy        <= 1'b1;
            bus.hex_codes   <= MSG_ERROR;
        end else begin
            case (state)
                IDLE: begin
                    if (!bus.clear && digit_ok) begin
                        state           <= ENTRY;
                        entry_buf       <= shift_buf;
                        bus.entry_count <= 3'd1;
                        bus.entry_full  <= (CODE_LEN == 1);
                        bus.hex_codes   <= shift_hex;
                    end else begin
                        bus.hex_codes <= idle_hex;
                    end
                end
                ENTRY: begin
                    if (bus.clear) begin
                        state           <= IDLE;
                        entry_buf       <= {CODE_LEN{DISP_DASH}};
                        bus.entry_count <= 3'd0;
                        bus.entry_full  <= 1'b0;
                        bus.hex_codes   <= idle_hex;
                    end else if (digit_ok) begin
                        entry_buf       <= shift_buf;
                        bus.entry_count <= bus.entry_count + 3'd1;
                        bus.entry_full  <= (bus.entry_count + 3'd1 == 3'(CODE_LEN));
                        bus.hex_codes   <= shift_hex;
                    end
                end
                ERROR: begin
                    if (tmr_active) begin
                        bus.hex_codes <= tmr_phase ? MSG_ERROR : MSG_BLANK;
                    end else begin
                        state         <= IDLE;
                        bus.busy      <= 1'b0;
                        bus.hex_codes <= idle_hex;
                    end
                end
                default: begin
                    state         <= IDLE;
                    bus.busy      <= 1'b0;
                    bus.hex_codes <= idle_hex;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lock_display_sequencer.sv
// Directed bench for lock_display_sequencer with short blink/error timing.
module tb_lock_display_sequencer;

    localparam logic [23:0] H_LOCKED   = 24'hFFF879;
    localparam logic [23:0] H_UNLOCKED = 24'hFAB879;
    localparam logic [23:0] H_ERR_ON   = 24'h56676F;
    localparam logic [23:0] H_ERR_OFF  = 24'hFFFFFF;

    logic clock;
    logic reset;
    int   checks;
    int   errors;
    logic [23:0] exp_hex;

    lock_display_sequencer_if #(.NUM_DISPLAYS(6)) bus ();

    lock_display_sequencer #(
        .NUM_DISPLAYS (6),
        .CODE_LEN     (4),
        .BLINK_CYCLES (4),
        .ERROR_CYCLES (16)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [23:0] hex, input logic [2:0] cnt,
                             input logic full, input logic busy);
        check({tag, ".hex"},   bus.hex_codes,           hex);
        check({tag, ".count"}, {21'd0, bus.entry_count}, {21'd0, cnt});
        check({tag, ".full"},  {23'd0, bus.entry_full},  {23'd0, full});
        check({tag, ".busy"},  {23'd0, bus.busy},        {23'd0, busy});
    endtask

    task automatic digit(input logic [2:0] v);
        bus.digit_valid = 1'b1;
        bus.digit_value = v;
        cyc();
        bus.digit_valid = 1'b0;
    endtask

    task automatic pulse_clear();
        bus.clear = 1'b1;
        cyc();
        bus.clear = 1'b0;
    endtask

    function automatic logic [23:0] blink_exp(input int k);
        return (((k - 1) / 4) % 2 == 0) ? H_ERR_ON : H_ERR_OFF;
    endfunction

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        bus.locked = 1'b1;
        bus.digit_valid = 1'b0;
        bus.digit_value = 3'd0;
        bus.clear = 1'b0;
        bus.error = 1'b0;
        cyc();
        cyc();
        check_all("reset", H_LOCKED, 3'd0, 1'b0, 1'b0);

        reset = 1'b0;
        bus.locked = 1'b0;
        cyc();
        check_all("release_unlocked", H_UNLOCKED, 3'd0, 1'b0, 1'b0);
        bus.locked = 1'b1;
        cyc();
        check("follow_locked", bus.hex_codes, H_LOCKED);

        digit(3'd7);
        check_all("illegal_digit", H_LOCKED, 3'd0, 1'b0, 1'b0);

        digit(3'd2);
        check_all("entry_1", 24'hFFFFF2, 3'd1, 1'b0, 1'b0);
        digit(3'd0);
        digit(3'd4);
        check("entry_3.hex", bus.hex_codes, 24'hFFF204);
        digit(3'd1);
        check_all("entry_full", 24'hFF2041, 3'd4, 1'b1, 1'b0);
        digit(3'd3);
        check_all("entry_overflow", 24'hFF2041, 3'd4, 1'b1, 1'b0);
        pulse_clear();
        check_all("clear_full", H_LOCKED, 3'd0, 1'b0, 1'b0);

        digit(3'd1);
        digit(3'd2);
        check_all("entry_12", 24'hFFFF12, 3'd2, 1'b0, 1'b0);
        pulse_clear();
        check_all("clear_12", H_LOCKED, 3'd0, 1'b0, 1'b0);

        // Error from ENTRY, full 16-cycle sequence.
        digit(3'd3);
        bus.error = 1'b1;
        cyc();
        bus.error = 1'b0;
        check_all("err_c1", H_ERR_ON, 3'd0, 1'b0, 1'b1);
        for (int k = 2; k <= 16; k++) begin
            cyc();
            exp_hex = blink_exp(k);
            check($sformatf("err_c%0d.hex", k), bus.hex_codes, exp_hex);
            check($sformatf("err_c%0d.busy", k), {23'd0, bus.busy}, 24'd1);
        end
        cyc();
        check_all("err_done", H_LOCKED, 3'd0, 1'b0, 1'b0);

        // Error restarted at cycle 10; clear and digit inside ERROR are ignored.
        bus.error = 1'b1;
        cyc();
        bus.error = 1'b0;
        check("rep_c1.hex", bus.hex_codes, H_ERR_ON);
        for (int k = 2; k <= 10; k++) begin
            cyc();
            bus.clear = 1'b0;
            bus.digit_valid = 1'b0;
            exp_hex = blink_exp(k);
            check($sformatf("rep_c%0d.hex", k), bus.hex_codes, exp_hex);
            check($sformatf("rep_c%0d.count", k), {21'd0, bus.entry_count}, 24'd0);
            if (k == 4) bus.clear = 1'b1;
            if (k == 5) begin
                bus.digit_valid = 1'b1;
                bus.digit_value = 3'd2;
            end
            if (k == 10) bus.error = 1'b1;
        end
        cyc();
        bus.error = 1'b0;
        check_all("rep2_c1", H_ERR_ON, 3'd0, 1'b0, 1'b1);
        for (int k = 2; k <= 16; k++) begin
            cyc();
            exp_hex = blink_exp(k);
            check($sformatf("rep2_c%0d.hex", k), bus.hex_codes, exp_hex);
            check($sformatf("rep2_c%0d.busy", k), {23'd0, bus.busy}, 24'd1);
        end
        cyc();
        check_all("rep2_done", H_LOCKED, 3'd0, 1'b0, 1'b0);

        // Simultaneous error+clear+digit while in ENTRY, unlocked.
        bus.locked = 1'b0;
        cyc();
        check("unlocked_idle", bus.hex_codes, H_UNLOCKED);
        digit(3'd1);
        check("entry_u1.hex", bus.hex_codes, 24'hFFFFF1);
        bus.error = 1'b1;
        bus.clear = 1'b1;
        bus.digit_valid = 1'b1;
        bus.digit_value = 3'd2;
        cyc();
        bus.error = 1'b0;
        bus.clear = 1'b0;
        bus.digit_valid = 1'b0;
        check_all("triple", H_ERR_ON, 3'd0, 1'b0, 1'b1);
        cyc();
        cyc();
        check("triple_c3.hex", bus.hex_codes, H_ERR_ON);

        // Asynchronous reset in the middle of ERROR.
        #2;
        reset = 1'b1;
        bus.locked = 1'b1;
        #1;
        check_all("async_reset", H_LOCKED, 3'd0, 1'b0, 1'b0);
        cyc();
        reset = 1'b0;
        bus.locked = 1'b0;
        cyc();
        check_all("post_reset", H_UNLOCKED, 3'd0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lock_display_sequencer.md
Name: lock_display_sequencer

Overview:
- Upstream driver for the per-digit hex-to-seven-segment encoders of the digital lock.
- Turns lock status, keypad digit entry and error events into one 4-bit display code per seven-segment digit.
- Handles the entry buffer, the status messages, the timed blinking "Error" message and all message sequencing.
- Each 4-bit slice of hex_codes feeds one encoder instance.

Parameters:
- NUM_DISPLAYS, 6, number of seven-segment digits driven; fixed at 6 for this design, range-checked.
- CODE_LEN, 4, maximum entered digits, 1..4.
- BLINK_CYCLES, 25000000, clock cycles per blink half-period in ERROR.
- ERROR_CYCLES, 150000000, total cycles the error message is shown.

Ports:
- clock  input  1  system clock
- reset  input  1  asynchronous, active-high
- locked  input  1  level; 1 = lock engaged, 0 = unlocked
- digit_valid  input  1  single-cycle strobe, digit_value valid
- digit_value  input  3  entered digit, legal 0..4
- clear  input  1  single-cycle strobe, discard entry
- error  input  1  single-cycle strobe, wrong code
- hex_codes  output  4*NUM_DISPLAYS  display codes; bits [3:0] = rightmost digit (index 0), bits [23:20] = leftmost (index 5)
- entry_count  output  3  digits currently held, 0..CODE_LEN
- entry_full  output  1  entry_count == CODE_LEN
- busy  output  1  high while in ERROR

Behaviour:
- Display codes: 0x0..0x4 = digits 0..4; 5=E, 6=r, 7=o, 8=L, 9=c, A=U, B=n; F = dash (encoder default). Codes C..E are never driven.
- All outputs are registered. A change is visible on the cycle after the causing input is sampled.
- On reset:
  - state IDLE; entry buffer cleared; entry_count=0; entry_full=0; busy=0.
  - hex_codes = F,F,F,8,7,9 (left to right, "---Loc"), independent of the locked input during reset.
- IDLE:
  - Shows "---Loc" (F,F,F,8,7,9) when locked=1.
  - Shows "-UnLoc" (F,A,B,8,7,9) when locked=0.
  - Follows changes of locked with 1-cycle latency.
- ENTRY:
  - Entered from IDLE by the first legal digit_valid.
  - Digits shift in at index 0; older digits move left.
  - Unused positions show F; indices at or above CODE_LEN always show F.
  - Example, CODE_LEN=4, digits 1 then 3: F,F,F,F,1,3.
- Digit rules:
  - digit_value > 4 is ignored.
  - digit_valid is ignored when entry_full=1.
- Leaving ENTRY by clear: clear empties the buffer (entry_count=0) and returns to IDLE.
- Leaving ENTRY without clear:
  - The block never leaves ENTRY on its own.
  - The upstream controller issues error or clear after consuming a full entry.
- ERROR:
  - Entered from any state by error.
  - Buffer cleared; busy=1.
  - Blink phase starts "on". "on" shows "Error-" (5,6,6,7,6,F); "off" shows all F.
  - Phase toggles every BLINK_CYCLES cycles.
  - After ERROR_CYCLES cycles: return to IDLE, busy=0.
- Priority in a single cycle: error > clear > digit_valid.
  - error while in ERROR restarts both counters and the phase.
  - clear and digit_valid are ignored while in ERROR.
- Counter widths: $clog2 of the respective parameter, minimum 1. Counters hold 0 outside ERROR.
- Reset mid-ERROR or mid-entry aborts immediately to the reset state.

Decomposition:
- Shared package lock_display_pkg holds:
  - the 4-bit display-code localparams (DISP_0..DISP_4, DISP_E, DISP_r, DISP_o, DISP_L, DISP_c, DISP_U, DISP_n, DISP_DASH=4'hF)
  - the state encoding (IDLE, ENTRY, ERROR)
  - the three fixed message constants (MSG_LOCKED, MSG_UNLOCKED, MSG_ERROR) as 24-bit code vectors.
- The encoder must interpret the codes exactly as defined here.
- One natural sub-module: lock_blink_timer.
  - Contains the error-duration counter and the blink-phase counter.
  - Inputs: clock, reset, start.
  - Outputs: active, phase.

Test Plan (BLINK_CYCLES=4, ERROR_CYCLES=16, CODE_LEN=4):
- Reset asserted mid-operation with locked=1 → hex_codes=24'hFFF879 immediately. Release with locked=0 → next cycle hex_codes=24'hFAB879.
- Digits 2,0,4,1, then digit 3 → after the 4th: hex_codes=24'hFF2041, entry_full=1. Digit 3 ignored, value unchanged.
- Digit_value=7 from IDLE → no change. Digits 1,2, then clear → hex_codes=24'hFFFF12, entry_count=2; after clear, returns to locked message, entry_count=0.
- Error from ENTRY → busy=1; hex_codes=24'h56676F for 4 cycles, 24'hFFFFFF for 4 cycles, repeating; IDLE message on cycle 17, busy=0.
- Error re-pulsed at cycle 10 of ERROR → ERROR lasts 16 cycles from the second pulse. Phase restarts "on". clear and digit_valid during ERROR have no effect.
- Same-cycle error+clear+digit_valid in ENTRY → ERROR entered, buffer cleared, digit discarded.
